// File: rtl/change_dispenser.sv
// Coin-return hopper sequencer: queues 10p/20p return requests, ejects them one at a time,
// confirms each coin on the hopper sensor and flags a jam when the sensor stays silent past the timeout.
module change_dispenser #(
   parameter int CNT_W       = 4,
   parameter int PULSE_CYC   = 3,
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ret10p,
   input  logic             ret20p,
   input  logic             ret20p2,
   input  logic             coin_sns,
   input  logic             clr_jam,
   output logic             hop10,
   output logic             hop20,
   output logic             busy,
   output logic             jam,
   output logic             ovf,
   output logic             done,
   output logic [CNT_W-1:0] pend10,
   output logic [CNT_W-1:0] pend20
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FIRE = 3'd1,
      S_WAIT = 3'd2,
      S_GAP  = 3'd3,
      S_JAM  = 3'd4
   } state_t;

   localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
   localparam logic [7:0] GAP_LAST   = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);
   localparam state_t     POST_COIN  = (GAP_CYC == 0) ? S_IDLE : S_GAP;

   // Saturating counter update; the top bit of the result flags a lost request.
   function automatic logic [CNT_W:0] sat_update(
      input logic [CNT_W-1:0] cur,
      input logic [1:0]       add,
      input logic             sub
   );
      logic [CNT_W+1:0] sum;
      sum = {2'b00, cur} + {{CNT_W{1'b0}}, add} - {{(CNT_W+1){1'b0}}, sub};
      if (sum > {2'b00, {CNT_W{1'b1}}}) begin
         sat_update = {1'b1, {CNT_W{1'b1}}};
      end else begin
         sat_update = {1'b0, sum[CNT_W-1:0]};
      end
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       tmr_q, tmr_d;
   logic             sel20_q, sel20_d;
   logic             retry_q, retry_d;
   logic             seen_q, seen_d;
   logic [CNT_W-1:0] pend10_q, pend10_d;
   logic [CNT_W-1:0] pend20_q, pend20_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             hop10_q, hop10_d;
   logic             hop20_q, hop20_d;
   logic             busy_q, busy_d;
   logic             jam_q, jam_d;

   logic             confirm_s;
   logic             dec10_s, dec20_s;
   logic [CNT_W:0]   upd10_s, upd20_s;

   // Next-state, queue counters and registered output values.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      sel20_d   = sel20_q;
      retry_d   = retry_q;
      seen_d    = seen_q;
      // Only the first sense of a fire cycle counts; senses outside FIRE/WAIT are ignored.
      confirm_s = coin_sns & (((state_q == S_FIRE) & ~seen_q) | (state_q == S_WAIT));

      case (state_q)
         S_IDLE: begin
            if (retry_q) begin
               state_d = S_FIRE;
               tmr_d   = 8'd0;
               seen_d  = 1'b0;
               retry_d = 1'b0;
            end else if ((pend20_q != {CNT_W{1'b0}}) || (pend10_q != {CNT_W{1'b0}})) begin
               state_d = S_FIRE;
               tmr_d   = 8'd0;
               seen_d  = 1'b0;
               sel20_d = (pend20_q != {CNT_W{1'b0}});
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FIRE: begin
            seen_d = seen_q | confirm_s;
            if (tmr_q == PULSE_LAST) begin
               if (seen_q | coin_sns) begin
                  state_d = POST_COIN;
                  tmr_d   = 8'd0;
               end else begin
                  state_d = S_WAIT;
                  tmr_d   = tmr_q + 8'd1;
               end
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         S_WAIT: begin
            if (coin_sns) begin
               state_d = POST_COIN;
               tmr_d   = 8'd0;
            end else if (tmr_q == TMO_LAST) begin
               state_d = S_JAM;
               tmr_d   = 8'd0;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         S_GAP: begin
            if (tmr_q == GAP_LAST) begin
               state_d = S_IDLE;
               tmr_d   = 8'd0;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         S_JAM: begin
            // The jammed coin was never decremented, so the retry reuses the latched select.
            if (clr_jam) begin
               state_d = S_IDLE;
               retry_d = 1'b1;
            end else begin
               state_d = S_JAM;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = 8'd0;
            retry_d = 1'b0;
         end
      endcase

      dec20_s  = confirm_s & sel20_q;
      dec10_s  = confirm_s & ~sel20_q;
      upd10_s  = sat_update(pend10_q, {1'b0, ret10p}, dec10_s);
      upd20_s  = sat_update(pend20_q, {ret20p2, ret20p}, dec20_s);
      pend10_d = upd10_s[CNT_W-1:0];
      pend20_d = upd20_s[CNT_W-1:0];
      ovf_d    = ovf_q | upd10_s[CNT_W] | upd20_s[CNT_W];
      done_d   = confirm_s & (pend10_d == {CNT_W{1'b0}}) & (pend20_d == {CNT_W{1'b0}});
      hop10_d  = (state_d == S_FIRE) & ~sel20_d;
      hop20_d  = (state_d == S_FIRE) & sel20_d;
      busy_d   = (state_d != S_IDLE);
      jam_d    = (state_d == S_JAM);
   end

   // State, counters and outputs; reset clears everything at once, including a live fire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         tmr_q    <= 8'd0;
         sel20_q  <= 1'b0;
         retry_q  <= 1'b0;
         seen_q   <= 1'b0;
         pend10_q <= {CNT_W{1'b0}};
         pend20_q <= {CNT_W{1'b0}};
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         hop10_q  <= 1'b0;
         hop20_q  <= 1'b0;
         busy_q   <= 1'b0;
         jam_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         sel20_q  <= sel20_d;
         retry_q  <= retry_d;
         seen_q   <= seen_d;
         pend10_q <= pend10_d;
         pend20_q <= pend20_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         hop10_q  <= hop10_d;
         hop20_q  <= hop20_d;
         busy_q   <= busy_d;
         jam_q    <= jam_d;
      end
   end

   assign hop10  = hop10_q;
   assign hop20  = hop20_q;
   assign busy   = busy_q;
   assign jam    = jam_q;
   assign ovf    = ovf_q;
   assign done   = done_q;
   assign pend10 = pend10_q;
   assign pend20 = pend20_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed scenarios followed by a randomized run checked against a coin-count/timing model.
module tb_change_dispenser;

   localparam int CNT_W   = 4;
   localparam int PULSE   = 3;
   localparam int GAP     = 2;
   localparam int TIMEOUT = 20;

   logic clk, rst;
   logic ret10p, ret20p, ret20p2, coin_sns, clr_jam;
   logic hop10, hop20, busy, jam, ovf, done;
   logic [CNT_W-1:0] pend10, pend20;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   change_dispenser #(
      .CNT_W(CNT_W), .PULSE_CYC(PULSE), .GAP_CYC(GAP), .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .ret10p(ret10p), .ret20p(ret20p), .ret20p2(ret20p2),
      .coin_sns(coin_sns), .clr_jam(clr_jam), .hop10(hop10), .hop20(hop20),
      .busy(busy), .jam(jam), .ovf(ovf), .done(done), .pend10(pend10), .pend20(pend20)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Wait for the next fire, check its coin type, sense on cycle d after fire start
   // (d<0: never) and measure the pulse width. Returns the fire start cycle.
   task automatic serve(input bit exp20, input int d, input string tag, output int f);
      int n, w, k;
      n = 0;
      while (!(hop10 || hop20) && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_fire"}, 32'(hop10 | hop20), 32'd1);
      f = cyc;
      chk({tag, "_hop20"}, 32'(hop20), 32'(exp20));
      chk({tag, "_hop10"}, 32'(hop10), 32'(!exp20));
      w = 0;
      k = 0;
      while ((k <= d || hop10 || hop20) && k < 40) begin
         if (hop10 || hop20) w++;
         coin_sns = (k == d);
         tick();
         k++;
      end
      coin_sns = 1'b0;
      chk({tag, "_width"}, 32'(w), 32'(PULSE));
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   int f1, f2, n0, n, c0;
   int m10, m20, idle_from, exp_fire, fire_f, d, hop_w, s_cyc;
   bit waiting, confirmed, prev_hop, fire20, dec20, dn, hop, sns;
   bit r10, r20, r22;

   initial begin
      rst = 1'b0; ret10p = 1'b0; ret20p = 1'b0; ret20p2 = 1'b0;
      coin_sns = 1'b0; clr_jam = 1'b0;
      #12;
      chk("rst_hop", 32'({hop10, hop20}), 32'd0);
      chk("rst_flags", 32'({busy, jam, ovf, done}), 32'd0);
      chk("rst_pend", 32'({pend10, pend20}), 32'd0);
      rst = 1'b1;
      tick();

      // 1) two 20p coins from one ret20p2, sense in FIRE
      n0 = cyc; ret20p2 = 1'b1; tick(); ret20p2 = 1'b0;
      chk("t1_pend20_q", 32'(pend20), 32'd2);
      chk("t1_busy_q", 32'(busy), 32'd0);
      serve(1'b1, 2, "t1a", f1);
      chk("t1_latency", 32'(f1 - n0), 32'd2);
      chk("t1_pend20_1", 32'(pend20), 32'd1);
      chk("t1_nodone", 32'(done), 32'd0);
      serve(1'b1, 2, "t1b", f2);
      chk("t1_spacing", 32'(f2 - f1), 32'(PULSE + GAP + 1));
      chk("t1_pend20_0", 32'(pend20), 32'd0);
      chk("t1_done", 32'(done), 32'd1);
      tick();
      chk("t1_done_pulse", 32'(done), 32'd0);
      wait_idle("t1", n);
      chk("t1_gap_len", 32'(n), 32'(GAP - 1));

      // 2) simultaneous 10p and 20p: 20p first; second sense lands in WAIT
      ret10p = 1'b1; ret20p = 1'b1; tick(); ret10p = 1'b0; ret20p = 1'b0;
      chk("t2_pend", 32'({pend10, pend20}), 32'({4'd1, 4'd1}));
      serve(1'b1, 1, "t2a", f1);
      chk("t2_mid_pend", 32'({pend10, pend20}), 32'({4'd1, 4'd0}));
      chk("t2_mid_done", 32'(done), 32'd0);
      serve(1'b0, 4, "t2b", f2);
      chk("t2_spacing", 32'(f2 - f1), 32'(PULSE + GAP + 1));
      chk("t2_final_pend", 32'({pend10, pend20}), 32'd0);
      chk("t2_done", 32'(done), 32'd1);
      wait_idle("t2", n);
      chk("t2_gap_len", 32'(n), 32'(GAP));

      // 3) no sense -> jam after the timeout
      ret10p = 1'b1; tick(); ret10p = 1'b0;
      serve(1'b0, -1, "t3", f1);
      n = 0;
      while (!jam && n < 40) begin
         tick();
         n++;
      end
      chk("t3_jam", 32'(jam), 32'd1);
      chk("t3_jam_time", 32'(cyc - f1), 32'(TIMEOUT));
      chk("t3_jam_pend10", 32'(pend10), 32'd1);
      chk("t3_jam_hops", 32'({hop10, hop20}), 32'd0);
      coin_sns = 1'b1; tick(); coin_sns = 1'b0;
      chk("t6_jam_sense_pend", 32'(pend10), 32'd1);
      chk("t6_jam_sense_done", 32'(done), 32'd0);

      // 4) saturate pend10 while jammed
      ret10p = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 13) begin
            chk("t4_pend_full", 32'(pend10), 32'd15);
            chk("t4_ovf_not_yet", 32'(ovf), 32'd0);
         end
      end
      ret10p = 1'b0;
      chk("t4_pend_clamp", 32'(pend10), 32'd15);
      chk("t4_ovf", 32'(ovf), 32'd1);
      chk("t4_still_jam", 32'(jam), 32'd1);
      ret20p = 1'b1; tick(); ret20p = 1'b0;
      chk("t4_queue_in_jam", 32'(pend20), 32'd1);

      // clear the jam: the 10p coin is retried even though a 20p is now queued
      c0 = cyc; clr_jam = 1'b1; tick(); clr_jam = 1'b0;
      chk("t3_clr_jam", 32'({jam, busy}), 32'd0);
      serve(1'b0, 2, "t3r", f1);
      chk("t3_retry_time", 32'(f1 - c0), 32'd2);
      chk("t3_retry_pend10", 32'(pend10), 32'd14);
      chk("t4_ovf_hold", 32'(ovf), 32'd1);

      // 5) reset in the middle of a 20p fire
      n = 0;
      while (!hop20 && n < 20) begin
         tick();
         n++;
      end
      chk("t5_fire20", 32'({hop10, hop20}), 32'({1'b0, 1'b1}));
      tick();
      chk("t5_midfire", 32'(hop20), 32'd1);
      rst = 1'b0;
      #1;
      chk("t5_rst_hop", 32'({hop10, hop20}), 32'd0);
      chk("t5_rst_flags", 32'({busy, jam, ovf, done}), 32'd0);
      chk("t5_rst_pend", 32'({pend10, pend20}), 32'd0);
      #1;
      rst = 1'b1;
      tick();
      chk("t5_after_busy", 32'({busy, hop10, hop20}), 32'd0);
      chk("t5_after_pend", 32'({pend10, pend20}), 32'd0);

      // 6) senses in GAP and IDLE are ignored
      ret10p = 1'b1; ret20p = 1'b1; tick(); ret10p = 1'b0; ret20p = 1'b0;
      serve(1'b1, 0, "t6a", f1);
      chk("t6_gap_busy", 32'(busy), 32'd1);
      coin_sns = 1'b1; tick(); coin_sns = 1'b0;
      chk("t6_gap_pend", 32'({pend10, pend20}), 32'({4'd1, 4'd0}));
      chk("t6_gap_done", 32'(done), 32'd0);
      serve(1'b0, 2, "t6b", f2);
      chk("t6_spacing", 32'(f2 - f1), 32'(PULSE + GAP + 1));
      chk("t6_done", 32'(done), 32'd1);
      wait_idle("t6", n);
      coin_sns = 1'b1; tick(); coin_sns = 1'b0;
      chk("t6_idle_pend", 32'({pend10, pend20}), 32'd0);
      chk("t6_idle_done", 32'(done), 32'd0);
      tick();
      chk("t6_idle_busy", 32'(busy), 32'd0);

      // Randomized run against a coin-count and timing model
      m10 = 0; m20 = 0; waiting = 1'b1; idle_from = cyc; exp_fire = -1;
      confirmed = 1'b1; prev_hop = 1'b0; fire_f = -1000; fire20 = 1'b0;
      d = 0; hop_w = 0; dec20 = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         r10 = (i < 600) && (m10 < 12) && ($urandom_range(0, 9) == 0);
         r20 = (i < 600) && (m20 < 12) && ($urandom_range(0, 9) == 0);
         r22 = (i < 600) && (m20 < 10) && ($urandom_range(0, 15) == 0);
         sns = !confirmed && (cyc == fire_f + d);
         ret10p = r10; ret20p = r20; ret20p2 = r22; coin_sns = sns;
         s_cyc = cyc;
         tick();
         ret10p = 1'b0; ret20p = 1'b0; ret20p2 = 1'b0; coin_sns = 1'b0;
         m10 += int'(r10);
         m20 += int'(r20) + 2 * int'(r22);
         dn = 1'b0;
         if (sns) begin
            if (fire20) m20--; else m10--;
            confirmed = 1'b1;
            dn = (m10 == 0) && (m20 == 0);
            idle_from = ((s_cyc > fire_f + PULSE - 1) ? s_cyc : fire_f + PULSE - 1) + GAP + 1;
            waiting = 1'b1;
         end
         chk("rnd_done", 32'(done), 32'(dn));
         chk("rnd_pend10", 32'(pend10), 32'(m10));
         chk("rnd_pend20", 32'(pend20), 32'(m20));
         chk("rnd_excl", 32'(hop10 & hop20), 32'd0);
         chk("rnd_jam", 32'(jam), 32'd0);
         hop = hop10 || hop20;
         if (hop && !prev_hop) begin
            chk("rnd_fire_time", 32'(cyc), 32'(exp_fire));
            chk("rnd_fire_sel", 32'(hop20), 32'(dec20));
            waiting = 1'b0; exp_fire = -1; fire_f = cyc; fire20 = hop20;
            confirmed = 1'b0; d = int'($urandom_range(0, 6)); hop_w = 0;
         end
         if (hop) hop_w++;
         if (!hop && prev_hop) chk("rnd_width", 32'(hop_w), 32'(PULSE));
         prev_hop = hop;
         chk("rnd_busy", 32'(busy), 32'(!(waiting && cyc >= idle_from)));
         if (waiting && exp_fire < 0 && cyc >= idle_from && (m10 + m20) > 0) begin
            exp_fire = cyc + 1;
            dec20 = (m20 > 0);
         end
      end
      chk("rnd_drain_pend", 32'({pend10, pend20}), 32'd0);
      chk("rnd_drain_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
